// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional performance counters are enabled with ARB_PERF_CNT_EN.
package mem_arb_pkg;

    localparam int unsigned ARB_I_DEF         = 32;
    localparam int unsigned ARB_N_DEF         = 8;
    localparam int unsigned ARB_R_DEF         = 6;
    localparam int unsigned ARB_MAX_WAIT_DEF  = 4;
    localparam int unsigned ARB_BURST_MAX_DEF = 8;

    typedef logic [ARB_R_DEF-1:0][ARB_N_DEF-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        DMA_OWN = 2'd2
    } arb_state_t;

    // Width needed to hold the values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
module arb_sat_counter #(
    parameter int unsigned W   = 3,
    parameter int unsigned MAX = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         at_max_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max_o = (cnt_q == W'(MAX));
    assign cnt_o    = cnt_q;

    // Next count: clear wins, otherwise increment until MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage (CPU) and the RSA
// operand loader (DMA). CPU has fixed priority; a starving DMA request is
// force-granted after MAX_WAIT losses, and locked DMA bursts are cut after
// BURST_MAX beats for one release cycle.
// Define ARB_PERF_CNT_EN to build the stall / beat performance counters.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned I         = ARB_I_DEF,
    parameter int unsigned N         = ARB_N_DEF,
    parameter int unsigned R         = ARB_R_DEF,
    parameter int unsigned MAX_WAIT  = ARB_MAX_WAIT_DEF,
    parameter int unsigned BURST_MAX = ARB_BURST_MAX_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cpu_req,
    input  logic           cpu_we,
    input  logic [I-1:0]   cpu_a,
    input  logic [R*N-1:0] cpu_wd,
    output logic           cpu_stall,
    output logic           cpu_rvalid,
    output logic [R*N-1:0] cpu_rd,
    input  logic           dma_req,
    input  logic           dma_lock,
    input  logic           dma_we,
    input  logic [I-1:0]   dma_a,
    input  logic [R*N-1:0] dma_wd,
    output logic           dma_gnt,
    output logic           dma_rvalid,
    output logic [R*N-1:0] dma_rd,
    output logic           mem_we,
    output logic [I-1:0]   mem_a,
    output logic [R*N-1:0] mem_wd,
    input  logic [R*N-1:0] mem_rd,
    output logic [31:0]    perf_cpu_stall_cnt,
    output logic [31:0]    perf_dma_beat_cnt
);

    localparam int unsigned WAIT_W = cnt_width(MAX_WAIT);
    localparam int unsigned BEAT_W = cnt_width(BURST_MAX);

    arb_state_t state_q;
    arb_state_t state_d;

    logic              cpu_win;
    logic              dma_win;
    logic              beat_last;
    logic              beat_at_max;
    logic              wait_at_max;
    logic [WAIT_W-1:0] wait_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic              beat_inc;
    logic              beat_clr;

    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic [R*N-1:0]    cpu_rd_q, cpu_rd_d;
    logic [R*N-1:0]    dma_rd_q, dma_rd_d;

    // beat_cnt counts every locked beat of the current burst, including the
    // beat that opened it, so a burst is exactly BURST_MAX grants long.
    assign beat_last = (beat_cnt == BEAT_W'(BURST_MAX - 1));

    // Winner selection; no grant at all while reset is asserted.
    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (!reset) begin
            if (dma_req && (state_q == DMA_OWN) && !beat_at_max) begin
                dma_win = 1'b1;
            end else if (dma_req && wait_at_max) begin
                dma_win = 1'b1;
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end else if (dma_req) begin
                dma_win = 1'b1;
            end
        end
    end

    // Next ownership state; the final beat of a full burst releases to IDLE.
    always_comb begin
        state_d = IDLE;
        if (dma_win) begin
            state_d = (dma_lock && !beat_last) ? DMA_OWN : IDLE;
        end else if (cpu_win) begin
            state_d = CPU_OWN;
        end
    end

    // Ownership state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign beat_inc = dma_win && dma_lock && (state_d == DMA_OWN);
    assign beat_clr = (state_d != DMA_OWN);

    arb_sat_counter #(
        .W   (WAIT_W),
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .clk_i    (clk),
        .rst_i    (reset),
        .inc_i    (dma_req && !dma_win),
        .clr_i    (dma_win || !dma_req),
        .cnt_o    (wait_cnt),
        .at_max_o (wait_at_max)
    );

    arb_sat_counter #(
        .W   (BEAT_W),
        .MAX (BURST_MAX)
    ) u_beat_cnt (
        .clk_i    (clk),
        .rst_i    (reset),
        .inc_i    (beat_inc),
        .clr_i    (beat_clr),
        .cnt_o    (beat_cnt),
        .at_max_o (beat_at_max)
    );

    // Memory port mux driven by the winner.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (dma_win) begin
            mem_we = dma_we;
            mem_a  = dma_a;
            mem_wd = dma_wd;
        end else if (cpu_win) begin
            mem_we = cpu_we;
            mem_a  = cpu_a;
            mem_wd = cpu_wd;
        end
    end

    assign cpu_stall = cpu_req && !cpu_win;
    assign dma_gnt   = dma_win;

    // Read-return next values: capture mem_rd for a granted read only.
    always_comb begin
        cpu_rvalid_d = cpu_win && !cpu_we;
        dma_rvalid_d = dma_win && !dma_we;
        cpu_rd_d     = cpu_rvalid_d ? mem_rd : cpu_rd_q;
        dma_rd_d     = dma_rvalid_d ? mem_rd : dma_rd_q;
    end

    // Read-return registers; reset discards any pending return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rd_q     <= '0;
            dma_rd_q     <= '0;
        end else begin
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rd_q     <= cpu_rd_d;
            dma_rd_q     <= dma_rd_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rd     = cpu_rd_q;
    assign dma_rd     = dma_rd_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_beat_q;

    // Wrapping event counters for stall cycles and granted DMA beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_beat_q  <= '0;
        end else begin
            if (cpu_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (dma_win) begin
                perf_beat_q <= perf_beat_q + 32'd1;
            end
        end
    end

    assign perf_cpu_stall_cnt = perf_stall_q;
    assign perf_dma_beat_cnt  = perf_beat_q;
`else
    assign perf_cpu_stall_cnt = '0;
    assign perf_dma_beat_cnt  = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios, a vector
// table for the starvation guard, and randomized traffic against a
// request/ownership model of the arbitration rules.
module tb_data_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned MAX_WAIT  = 4;
    localparam int unsigned BURST_MAX = 8;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_a;
    logic [47:0] cpu_wd;
    logic        cpu_stall, cpu_rvalid;
    logic [47:0] cpu_rd;
    logic        dma_req, dma_lock, dma_we;
    logic [31:0] dma_a;
    logic [47:0] dma_wd;
    logic        dma_gnt, dma_rvalid;
    logic [47:0] dma_rd;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [47:0] mem_wd;
    logic [47:0] mem_rd;
    logic [31:0] perf_cpu_stall_cnt, perf_dma_beat_cnt;

    data_mem_arbiter #(
        .I         (32),
        .N         (8),
        .R         (6),
        .MAX_WAIT  (MAX_WAIT),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_req            (cpu_req),
        .cpu_we             (cpu_we),
        .cpu_a              (cpu_a),
        .cpu_wd             (cpu_wd),
        .cpu_stall          (cpu_stall),
        .cpu_rvalid         (cpu_rvalid),
        .cpu_rd             (cpu_rd),
        .dma_req            (dma_req),
        .dma_lock           (dma_lock),
        .dma_we             (dma_we),
        .dma_a              (dma_a),
        .dma_wd             (dma_wd),
        .dma_gnt            (dma_gnt),
        .dma_rvalid         (dma_rvalid),
        .dma_rd             (dma_rd),
        .mem_we             (mem_we),
        .mem_a              (mem_a),
        .mem_wd             (mem_wd),
        .mem_rd             (mem_rd),
        .perf_cpu_stall_cnt (perf_cpu_stall_cnt),
        .perf_dma_beat_cnt  (perf_dma_beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten memory words hold an address-derived pattern.
    function automatic lane_vec_t init_pat(input logic [5:0] a);
        lane_vec_t v;
        for (int k = 0; k < 6; k++) v[k] = 8'(a * 7 + k);
        return v;
    endfunction

    // Environment memory, updated only by what the DUT issues.
    lane_vec_t env_mem [64];
    bit        env_wr  [64];
    assign mem_rd = env_wr[mem_a[5:0]] ? env_mem[mem_a[5:0]] : init_pat(mem_a[5:0]);
    always @(posedge clk) begin
        if (mem_we) begin
            env_mem[mem_a[5:0]] <= mem_wd;
            env_wr[mem_a[5:0]]  <= 1'b1;
        end
    end

    // Reference model state.
    lane_vec_t   ref_mem [64];
    bit          ref_wr  [64];
    int unsigned m_burst, m_wait, m_perf_stall, m_perf_beat;
    bit          m_cpu_rv, m_dma_rv, m_cpu_won, m_dma_won;
    lane_vec_t   m_cpu_rd, m_dma_rd;

    // Values sampled in the last cycle, for directed checks.
    logic        s_cpu_stall, s_dma_gnt, s_mem_we, s_cpu_rvalid, s_dma_rvalid;
    logic [47:0] s_cpu_rd, s_dma_rd;
    logic [31:0] s_perf_stall, s_perf_beat;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic lane_vec_t ref_read(input logic [5:0] a);
        return ref_wr[a] ? ref_mem[a] : init_pat(a);
    endfunction

    // One clock cycle: inputs are already driven (at posedge+1); predict,
    // sample at the falling edge, compare, then advance the model.
    task automatic run_cycle();
        bit cw, dw, e_we;
        if (reset) begin
            m_burst = 0; m_wait = 0; m_cpu_rv = 0; m_dma_rv = 0;
            m_cpu_rd = '0; m_dma_rd = '0; m_perf_stall = 0; m_perf_beat = 0;
        end
        cw = 0; dw = 0;
        if (!reset) begin
            if (dma_req && m_burst > 0 && m_burst < BURST_MAX) dw = 1;
            else if (dma_req && m_wait == MAX_WAIT) dw = 1;
            else if (cpu_req) cw = 1;
            else if (dma_req) dw = 1;
        end
        e_we = dw ? dma_we : (cw ? cpu_we : 1'b0);
        #4;
        s_cpu_stall = cpu_stall; s_dma_gnt = dma_gnt; s_mem_we = mem_we;
        s_cpu_rvalid = cpu_rvalid; s_dma_rvalid = dma_rvalid;
        s_cpu_rd = cpu_rd; s_dma_rd = dma_rd;
        s_perf_stall = perf_cpu_stall_cnt; s_perf_beat = perf_dma_beat_cnt;
        chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !cw));
        chk("dma_gnt", 64'(dma_gnt), 64'(dw));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        if (dw) begin
            chk("mem_a_dma", 64'(mem_a), 64'(dma_a));
            chk("mem_wd_dma", 64'(mem_wd), 64'(dma_wd));
        end else if (cw) begin
            chk("mem_a_cpu", 64'(mem_a), 64'(cpu_a));
            chk("mem_wd_cpu", 64'(mem_wd), 64'(cpu_wd));
        end
        chk("cpu_rvalid", 64'(cpu_rvalid), 64'(m_cpu_rv));
        chk("dma_rvalid", 64'(dma_rvalid), 64'(m_dma_rv));
        if (m_cpu_rv) chk("cpu_rd", 64'(cpu_rd), 64'(m_cpu_rd));
        if (m_dma_rv) chk("dma_rd", 64'(dma_rd), 64'(m_dma_rd));
`ifdef ARB_PERF_CNT_EN
        chk("perf_stall", 64'(perf_cpu_stall_cnt), 64'(m_perf_stall));
        chk("perf_beat", 64'(perf_dma_beat_cnt), 64'(m_perf_beat));
`else
        chk("perf_stall", 64'(perf_cpu_stall_cnt), 64'd0);
        chk("perf_beat", 64'(perf_dma_beat_cnt), 64'd0);
`endif
        if (!reset) begin
            m_cpu_rv = cw && !cpu_we;
            m_dma_rv = dw && !dma_we;
            if (m_cpu_rv) m_cpu_rd = ref_read(cpu_a[5:0]);
            if (m_dma_rv) m_dma_rd = ref_read(dma_a[5:0]);
            if (cw && cpu_we) begin ref_mem[cpu_a[5:0]] = cpu_wd; ref_wr[cpu_a[5:0]] = 1; end
            if (dw && dma_we) begin ref_mem[dma_a[5:0]] = dma_wd; ref_wr[dma_a[5:0]] = 1; end
            if (dw && dma_lock) begin
                m_burst++;
                if (m_burst == BURST_MAX) m_burst = 0;
            end else begin
                m_burst = 0;
            end
            if (dma_req && !dw) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else m_wait = 0;
            if (cpu_req && !cw) m_perf_stall++;
            if (dw) m_perf_beat++;
        end
        m_cpu_won = cw; m_dma_won = dw;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_a = '0; cpu_wd = '0;
        dma_req = 0; dma_lock = 0; dma_we = 0; dma_a = '0; dma_wd = '0;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        reset = 1; run_cycle();
        reset = 0;
    endtask

    typedef struct {
        bit cpu_req;
        bit dma_req;
        bit dma_lock;
        bit exp_stall;
        bit exp_dgnt;
    } vec_t;
    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 0;
        #1 reset = 1;
        @(posedge clk); #1;
        run_cycle();
        chk("rst_cpu_rvalid", 64'(s_cpu_rvalid), 64'd0);
        chk("rst_cpu_rd", 64'(s_cpu_rd), 64'd0);
        chk("rst_perf_stall", 64'(s_perf_stall), 64'd0);
        reset = 0;

        // Preload 0x10 with 7 in every lane via a DMA write, then CPU read.
        dma_req = 1; dma_we = 1; dma_a = 32'h10; dma_wd = {6{8'd7}};
        run_cycle();
        idle_inputs();
        cpu_req = 1; cpu_a = 32'h10;
        run_cycle();
        chk("t1_stall", 64'(s_cpu_stall), 64'd0);
        cpu_req = 0;
        run_cycle();
        chk("t1_rvalid", 64'(s_cpu_rvalid), 64'd1);
        chk("t1_rd", 64'(s_cpu_rd), 64'h0707_0707_0707);

        // DMA writes lanes 1..6 to 0x20, CPU reads it back.
        dma_req = 1; dma_we = 1; dma_a = 32'h20; dma_wd = 48'h06_05_04_03_02_01;
        run_cycle();
        chk("t6_dgnt", 64'(s_dma_gnt), 64'd1);
        chk("t6_mem_we", 64'(s_mem_we), 64'd1);
        idle_inputs();
        cpu_req = 1; cpu_a = 32'h20;
        run_cycle();
        cpu_req = 0;
        run_cycle();
        chk("t6_rvalid", 64'(s_cpu_rvalid), 64'd1);
        chk("t6_rd", 64'(s_cpu_rd), 64'h0605_0403_0201);

        // Starvation guard: both requesting for 6 cycles.
        reset_pulse();
        for (int i = 0; i < 6; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, (i == 4), (i == 4)};
        cpu_a = 32'h11; dma_a = 32'h12;
        for (int i = 0; i < 6; i++) begin
            cpu_req = tbl[i].cpu_req; dma_req = tbl[i].dma_req; dma_lock = tbl[i].dma_lock;
            run_cycle();
            chk($sformatf("t2_stall[%0d]", i), 64'(s_cpu_stall), 64'(tbl[i].exp_stall));
            chk($sformatf("t2_dgnt[%0d]", i), 64'(s_dma_gnt), 64'(tbl[i].exp_dgnt));
        end
        idle_inputs();
        run_cycle();
`ifdef ARB_PERF_CNT_EN
        chk("t5_perf_stall", 64'(s_perf_stall), 64'd1);
        chk("t5_perf_beat", 64'(s_perf_beat), 64'd1);
`else
        chk("t5_perf_stall", 64'(s_perf_stall), 64'd0);
        chk("t5_perf_beat", 64'(s_perf_beat), 64'd0);
`endif

        // Locked burst of 10 writes; CPU requests from the third cycle.
        for (int c = 0; c < 11; c++) begin
            int beat;
            beat = (c < 8) ? c : c - 1;
            dma_req = 1; dma_we = 1; dma_lock = (beat != 9);
            dma_a = 32'(8'h28 + beat); dma_wd = 48'(beat * 48'h0101_0101_0101);
            cpu_req = (c >= 2 && c <= 8); cpu_we = 0; cpu_a = 32'h2;
            run_cycle();
            chk($sformatf("t3_dgnt[%0d]", c), 64'(s_dma_gnt), 64'(c != 8));
            chk($sformatf("t3_stall[%0d]", c), 64'(s_cpu_stall), 64'(c >= 2 && c <= 7));
        end
        idle_inputs();
        run_cycle();

        // Reset in the cycle after a granted DMA read of a locked burst.
        dma_req = 1; dma_lock = 1; dma_we = 0; dma_a = 32'h05;
        run_cycle();
        chk("t4_dgnt", 64'(s_dma_gnt), 64'd1);
        reset = 1; dma_we = 1;
        run_cycle();
        chk("t4_rvalid", 64'(s_dma_rvalid), 64'd0);
        chk("t4_mem_we", 64'(s_mem_we), 64'd0);
        chk("t4_rst_dgnt", 64'(s_dma_gnt), 64'd0);
        reset = 0; cpu_req = 1; cpu_we = 0; cpu_a = 32'h06;
        run_cycle();
        chk("t4_cpu_first", 64'(s_cpu_stall), 64'd0);
        chk("t4_dma_lost", 64'(s_dma_gnt), 64'd0);
        idle_inputs();
        run_cycle();

        // Random traffic; requests and payloads are held until granted.
        for (int n = 0; n < 600; n++) begin
            if (!cpu_req || m_cpu_won) begin
                cpu_req = ($urandom_range(0, 99) < 55);
                cpu_we  = $urandom_range(0, 1) == 1;
                cpu_a   = $urandom_range(0, 63);
                cpu_wd  = 48'({$urandom(), $urandom()});
            end
            if (!dma_req || m_dma_won) begin
                dma_req  = ($urandom_range(0, 99) < 75);
                dma_lock = ($urandom_range(0, 99) < 80);
                dma_we   = $urandom_range(0, 1) == 1;
                dma_a    = $urandom_range(0, 63);
                dma_wd   = 48'({$urandom(), $urandom()});
            end
            reset = ($urandom_range(0, 199) == 0);
            run_cycle();
        end
        reset = 0;
        idle_inputs();
        run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
